// File: rtl/microondas_pkg.sv
// microondas_pkg: shared state encoding, BCD limits and timing defaults
package microondas_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, COOK = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;
  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
  localparam int DONE_HOLD_DEF = 300;
endpackage

// File: rtl/microondas_controle_dec.sv
// bcd_mmss_dec: one-second decrement of a BCD mm:ss value with borrow ripple
module bcd_mmss_dec
  import microondas_pkg::*;
(
  input  logic [3:0] i_min_tens,
  input  logic [3:0] i_min_ones,
  input  logic [3:0] i_sec_tens,
  input  logic [3:0] i_sec_ones,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_is_zero_next
);
  logic w_b0, w_b1, w_b2;
  // borrow ripples upward; seconds-tens wrap to 5 so entered values above 59 count linearly until they wrap
  always_comb begin
    w_b0 = i_sec_ones == 4'd0;
    w_b1 = w_b0 && i_sec_tens == 4'd0;
    w_b2 = w_b1 && i_min_ones == 4'd0;
    o_sec_ones = w_b0 ? BCD_ONES_MAX : i_sec_ones - 4'd1;
    o_sec_tens = !w_b0 ? i_sec_tens : w_b1 ? BCD_TENS_MAX : i_sec_tens - 4'd1;
    o_min_ones = !w_b1 ? i_min_ones : w_b2 ? BCD_ONES_MAX : i_min_ones - 4'd1;
    o_min_tens = w_b2 ? i_min_tens - 4'd1 : i_min_tens;
    o_is_zero_next = {o_min_tens, o_min_ones, o_sec_tens, o_sec_ones} == 16'd0;
  end
endmodule

// File: rtl/microondas_controle.sv
// microondas_controle: time register and cook FSM for the microwave timer
module microondas_controle
  import microondas_pkg::*;
#(
  parameter int DONE_HOLD = DONE_HOLD_DEF,
  parameter int CNT_W     = 9
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       magnetron_on,
  output logic       done
);
  state_t r_state, w_state_nx;
  logic [15:0] r_time, w_time_nx, w_time_dec;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic r_loadn_q, r_startn_q, r_pgt_q, r_enablen, r_mag, r_done;
  logic w_ld_ev, w_st_ev, w_tk_ev, w_zero_next;
  assign {min_tens, min_ones, sec_tens, sec_ones} = r_time;
  assign enablen      = r_enablen;
  assign magnetron_on = r_mag;
  assign done         = r_done;
  bcd_mmss_dec u_dec (
    .i_min_tens     (r_time[15:12]),
    .i_min_ones     (r_time[11:8]),
    .i_sec_tens     (r_time[7:4]),
    .i_sec_ones     (r_time[3:0]),
    .o_min_tens     (w_time_dec[15:12]),
    .o_min_ones     (w_time_dec[11:8]),
    .o_sec_tens     (w_time_dec[7:4]),
    .o_sec_ones     (w_time_dec[3:0]),
    .o_is_zero_next (w_zero_next)
  );
  // next state, next time and hold counter; clear beats stop/door, which beat the tick
  always_comb begin
    w_ld_ev    = r_loadn_q & ~loadn;
    w_st_ev    = r_startn_q & ~startn;
    w_tk_ev    = ~r_pgt_q & pgt_1Hz;
    w_state_nx = r_state;
    w_time_nx  = r_time;
    w_cnt_nx   = '0;
    case (r_state)
      IDLE:
        if (!clearn) w_time_nx = '0;
        else begin
          if (w_ld_ev && D <= BCD_ONES_MAX) w_time_nx = {r_time[11:0], D};
          if (w_st_ev && door_closed && r_time != 16'd0) w_state_nx = COOK;
        end
      COOK:
        if (!clearn) begin
          w_state_nx = IDLE;
          w_time_nx  = '0;
        end else if (!door_closed || !stopn) w_state_nx = PAUSE;
        else if (w_tk_ev) begin
          w_time_nx  = w_time_dec;
          w_state_nx = w_zero_next ? DONE : COOK;
        end
      PAUSE:
        if (!clearn) begin
          w_state_nx = IDLE;
          w_time_nx  = '0;
        end else if (w_st_ev && door_closed) w_state_nx = COOK;
      DONE:
        if (!clearn || r_cnt == CNT_W'(DONE_HOLD - 1)) w_state_nx = IDLE;
        else w_cnt_nx = r_cnt + 1'b1;
      default: w_state_nx = IDLE;
    endcase
  end
  // state, time, edge history and outputs registered from the next state
  always_ff @(posedge clk100) begin
    if (reset) begin
      r_state    <= IDLE;
      r_time     <= '0;
      r_cnt      <= '0;
      r_loadn_q  <= 1'b1;
      r_startn_q <= 1'b1;
      r_pgt_q    <= 1'b0;
      r_enablen  <= 1'b0;
      r_mag      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_time     <= w_time_nx;
      r_cnt      <= w_cnt_nx;
      r_loadn_q  <= loadn;
      r_startn_q <= startn;
      r_pgt_q    <= pgt_1Hz;
      r_enablen  <= w_state_nx != IDLE;
      r_mag      <= w_state_nx == COOK;
      r_done     <= w_state_nx == DONE;
    end
  end
endmodule

// File: doc/microondas_controle.md
Name: microondas_controle

Overview:
- Top-level sequencer for the microwave timer datapath.
- Takes the encoded digit stream (D, loadn) and the 1 Hz square wave (pgt_1Hz) from timer_controle.
- Owns the 4-digit BCD mm:ss time register and the cook FSM.
- Drives timer_controle's enablen (keypad gating) and the magnetron enable.

Parameters:
- DONE_HOLD, 300: clk100 cycles that `done` stays high after the count reaches 00:00 (3 s at 100 Hz).
- CNT_W, 9: width of the DONE hold counter; must satisfy 2^CNT_W > DONE_HOLD.

Ports:
- clk100  in  1  system clock (100 Hz); all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- D  in  4  digit code from timer_controle; a value >9 is invalid.
- loadn  in  1  active-low digit strobe from timer_controle.
- pgt_1Hz  in  1  1 Hz square wave from timer_controle.
- startn  in  1  active-low start button, level.
- stopn  in  1  active-low stop/pause button, level.
- clearn  in  1  active-low clear button, level.
- door_closed  in  1  1 = door closed.
- enablen  out  1  to timer_controle; 0 = keypad entry enabled.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD time register.
- magnetron_on  out  1  heating enable.
- done  out  1  cook-complete indicator.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - All four digits = 0.
  - enablen = 0, magnetron_on = 0, done = 0.
  - Hold counter = 0.
  - Edge registers: loadn_q = 1, startn_q = 1, pgt_q = 0.
- Edge events, each evaluated for one cycle:
  - ld_ev = loadn_q & ~loadn.
  - st_ev = startn_q & ~startn.
  - tk_ev = ~pgt_q & pgt_1Hz.
  - clearn, stopn and door_closed are used as levels.
- States: IDLE, COOK, PAUSE, DONE.
- IDLE:
  - enablen = 0, magnetron_on = 0.
  - ld_ev with D<=9: shift left in the same cycle. min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. The oldest digit is lost.
  - ld_ev with D>9: ignored.
  - clearn=0: all digits cleared to 0; this overrides ld_ev.
  - st_ev & door_closed & time!=0: go to COOK. magnetron_on and enablen go to 1 on the next edge (1-cycle latency).
  - st_ev with the door open or time==0: ignored. The button must be released and pressed again.
- COOK, priority from highest to lowest:
  - clearn=0: go to IDLE and zero the time.
  - ~door_closed or stopn=0: go to PAUSE; the time is held.
  - tk_ev: decrement mm:ss (rules below).
  - magnetron_on=1 and enablen=1 while in COOK.
  - ld_ev is ignored.
- Decrement rules:
  - sec_ones 0 wraps to 9 with a borrow.
  - sec_tens 0 wraps to 5 with a borrow.
  - min_ones 0 wraps to 9 with a borrow.
  - min_tens takes the final borrow.
  - Entered seconds above 59 (e.g. 0:99) are legal. They count down linearly until sec_tens wraps.
  - If the decremented value equals 00:00: go to DONE, clear magnetron_on on the same edge.
- PAUSE:
  - magnetron_on = 0, enablen = 1; the time is held and tk_ev is ignored.
  - st_ev & door_closed: return to COOK.
  - clearn=0: go to IDLE and zero the time.
- DONE:
  - done = 1, magnetron_on = 0, enablen = 1.
  - The hold counter increments every cycle. When it reaches DONE_HOLD-1: go to IDLE, done=0, counter=0.
  - clearn=0: go to IDLE immediately.
- Simultaneous events:
  - clear beats stop/door; stop/door beats tick. No decrement occurs in the cycle that pause is taken.
- Reset:
  - Reset mid-operation (any state) returns everything to reset values on the next edge.
  - Reset dominates every other input.

Decomposition:
- Package microondas_pkg holds the state encoding (IDLE=0, COOK=1, PAUSE=2, DONE=3), the BCD limits (9, 5) and the DONE_HOLD default.
- One combinational sub-module, bcd_mmss_dec: takes the four digits and returns the decremented digits plus an is_zero_next flag.

Test Plan:
- Digit entry: reset; pulse loadn low with D=1,3,0 -> digits read 01:30. Then D=12 -> 01:30 unchanged. clearn=0 -> 00:00.
- Basic cook: time 00:03, door_closed=1, startn pulse -> magnetron_on=1, enablen=1 one cycle later. Sequence 00:02, 00:01 on successive pgt_1Hz rises, then DONE. done high exactly 300 cycles, then IDLE, enablen=0.
- Borrow chain: load 10:00, cook, one tick -> 09:59. Load 00:99 -> ticks 00:98 … 00:90, 00:89.
- Pause/resume: cooking 00:05; open the door in the same cycle as a tk_ev -> PAUSE with 00:05 held, magnetron_on=0. Close the door and pulse startn -> COOK, continues 00:04.
- Guards: start with 00:00, or with door_closed=0 -> stays IDLE, magnetron_on=0. Hold startn low, then close the door -> still IDLE.
- Reset mid-cook at 00:42 -> next edge: IDLE, 00:00, all outputs 0.
